// File: rtl/sp_ram_param.sv
// Single-port byte-lane RAM with a selectable read/write collision mode and a hardware clear sequencer.
// Optional output register stage: define SP_RAM_OUTREG_EN for a read latency of 2 instead of 1.
//
// state    | meaning
// ST_RESET | held in reset, array untouched, busy
// ST_CLEAR | zeroing address r_cnt each cycle, busy
// ST_READY | accepting accesses and clear requests
module sp_ram_param #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 6,
   parameter int BYTE_W     = 8,
   parameter int WRITE_MODE = 0
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       en,
   input  logic [DATA_W/BYTE_W-1:0]   we,
   input  logic [ADDR_W-1:0]          address,
   input  logic [DATA_W-1:0]          DI,
   input  logic                       clr,
   output logic [DATA_W-1:0]          DO,
   output logic                       do_valid,
   output logic                       busy
);

   localparam int NB    = DATA_W / BYTE_W;
   localparam int DEPTH = 1 << ADDR_W;
   // Out-of-range modes fall back to read-first.
   localparam int WM    = (WRITE_MODE == 1 || WRITE_MODE == 2) ? WRITE_MODE : 0;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_CLEAR = 2'd1,
      ST_READY = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_cnt;
   logic [ADDR_W-1:0]   w_cnt_nxt;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   w_rd;
   logic [DATA_W-1:0]   w_merged;
   logic [DATA_W-1:0]   r_do;
   logic                r_vld;
   logic                w_access;
   logic                w_clr_wr;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state <= ST_RESET;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_RESET: begin
            w_state_nxt = ST_CLEAR;
            w_cnt_nxt   = '0;
         end
         ST_CLEAR: begin
            if (r_cnt == LAST) begin
               w_state_nxt = ST_READY;
            end else begin
               w_cnt_nxt = r_cnt + ADDR_W'(1);
            end
         end
         ST_READY: begin
            if (clr) begin
               w_state_nxt = ST_CLEAR;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_RESET;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign busy     = (r_state != ST_READY);
   // A clear request in the same cycle as an access drops the access.
   assign w_access = (r_state == ST_READY) && en && !clr;
   assign w_clr_wr = (r_state == ST_CLEAR);
   assign w_rd     = r_mem[address];

   always_comb begin
      w_merged = w_rd;
      for (int i = 0; i < NB; i++) begin
         if (we[i]) begin
            w_merged[i*BYTE_W +: BYTE_W] = DI[i*BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST_N) begin
         if (w_clr_wr) begin
            r_mem[r_cnt] <= '0;
         end else if (w_access) begin
            r_mem[address] <= w_merged;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_do  <= '0;
         r_vld <= 1'b0;
      end else begin
         r_vld <= 1'b0;
         if (w_access) begin
            if (we == '0) begin
               r_do  <= w_rd;
               r_vld <= 1'b1;
            end else if (WM == 1) begin
               r_do  <= w_merged;
               r_vld <= 1'b1;
            end else if (WM == 0) begin
               r_do  <= w_rd;
               r_vld <= 1'b1;
            end
         end
      end
   end

`ifdef SP_RAM_OUTREG_EN
   logic [DATA_W-1:0] r_do_q;
   logic              r_vld_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_do_q  <= '0;
         r_vld_q <= 1'b0;
      end else begin
         r_do_q  <= r_do;
         r_vld_q <= r_vld;
      end
   end

   assign DO       = r_do_q;
   assign do_valid = r_vld_q;
`else
   assign DO       = r_do;
   assign do_valid = r_vld;
`endif

endmodule

// File: tb/tb_sp_ram_param.sv
// Directed bench for sp_ram_param: four instances (modes 0,1,2 and illegal 3) share one stimulus stream.
// Honours SP_RAM_OUTREG_EN for the expected read latency.
module tb_sp_ram_param;

   localparam int DW = 16;
   localparam int AW = 6;
   localparam int NB = 2;

   logic          CLK     = 1'b0;
   logic          RST_N   = 1'b0;
   logic          en      = 1'b0;
   logic          clr     = 1'b0;
   logic [NB-1:0] we      = '0;
   logic [AW-1:0] address = '0;
   logic [DW-1:0] DI      = '0;

   logic [DW-1:0] dout [4];
   logic          dv   [4];
   logic          bz   [4];

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      sp_ram_param #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(8), .WRITE_MODE(g)) u_dut (
         .CLK      (CLK),
         .RST_N    (RST_N),
         .en       (en),
         .we       (we),
         .address  (address),
         .DI       (DI),
         .clr      (clr),
         .DO       (dout[g]),
         .do_valid (dv[g]),
         .busy     (bz[g])
      );
   end

   // Drive one access; returns sampled at the cycle the result is due.
   task automatic access(input logic e, input logic [NB-1:0] w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
      @(negedge CLK);
      en = e; we = w; address = a; DI = d;
      @(posedge CLK); #1;
      en = 1'b0; we = '0;
`ifdef SP_RAM_OUTREG_EN
      @(posedge CLK); #1;
`endif
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (bz[0] === 1'b1 && n < 200) begin
         n++;
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      for (int g = 0; g < 4; g++) begin
         checks++;
         if (dout[g] !== 16'h0000 || dv[g] !== 1'b0 || bz[g] !== 1'b1) begin
            errors++;
            $display("FAIL reset dut%0d: DO=%h valid=%b busy=%b, expected 0000/0/1", g, dout[g], dv[g], bz[g]);
         end
      end
   endtask

   task automatic test_power_up_clear();
      int n;
      @(negedge CLK); RST_N = 1'b1;
      @(posedge CLK); #1;
      count_busy(n);
      checks++;
      if (n !== 64) begin
         errors++;
         $display("FAIL powerup_busy_cycles: got %0d, expected 64", n);
      end
      for (int g = 0; g < 4; g++) begin
         checks++;
         if (bz[g] !== 1'b0) begin
            errors++;
            $display("FAIL ready_busy dut%0d: busy=%b, expected 0", g, bz[g]);
         end
      end
      for (int a = 0; a < 64; a++) begin
         access(1'b1, 2'b00, AW'(a), 16'h0);
         for (int g = 0; g < 4; g++) begin
            checks++;
            if (dout[g] !== 16'h0000 || dv[g] !== 1'b1) begin
               errors++;
               $display("FAIL cleared_read dut%0d addr %0d: DO=%h valid=%b, expected 0000/1", g, a, dout[g], dv[g]);
            end
         end
      end
   endtask

   task automatic test_read_first();
      logic [DW-1:0] prev2;
      logic [DW-1:0] exp_do [4];
      logic          exp_v  [4];
      access(1'b1, 2'b11, 6'd5, 16'h1234);
      prev2 = dout[2];
      access(1'b1, 2'b11, 6'd5, 16'hABCD);
      exp_do = '{16'h1234, 16'hABCD, prev2, 16'h1234};
      exp_v  = '{1'b1, 1'b1, 1'b0, 1'b1};
      for (int g = 0; g < 4; g++) begin
         checks++;
         if (dout[g] !== exp_do[g] || dv[g] !== exp_v[g]) begin
            errors++;
            $display("FAIL collision_full dut%0d: DO=%h valid=%b, expected %h/%b", g, dout[g], dv[g], exp_do[g], exp_v[g]);
         end
      end
      access(1'b1, 2'b00, 6'd5, 16'h0);
      for (int g = 0; g < 4; g++) begin
         checks++;
         if (dout[g] !== 16'hABCD || dv[g] !== 1'b1) begin
            errors++;
            $display("FAIL readback5 dut%0d: DO=%h valid=%b, expected abcd/1", g, dout[g], dv[g]);
         end
      end
   endtask

   task automatic test_write_first();
      logic [DW-1:0] prev2;
      logic [DW-1:0] exp_do [4];
      logic          exp_v  [4];
      access(1'b1, 2'b11, 6'd7, 16'hAAAA);
      prev2 = dout[2];
      access(1'b1, 2'b01, 6'd7, 16'h5555);
      exp_do = '{16'hAAAA, 16'hAA55, prev2, 16'hAAAA};
      exp_v  = '{1'b1, 1'b1, 1'b0, 1'b1};
      for (int g = 0; g < 4; g++) begin
         checks++;
         if (dout[g] !== exp_do[g] || dv[g] !== exp_v[g]) begin
            errors++;
            $display("FAIL collision_lane0 dut%0d: DO=%h valid=%b, expected %h/%b", g, dout[g], dv[g], exp_do[g], exp_v[g]);
         end
      end
      access(1'b1, 2'b10, 6'd7, 16'h1234);
      checks++;
      if (dout[1] !== 16'h1255 || dv[1] !== 1'b1) begin
         errors++;
         $display("FAIL collision_lane1 dut1: DO=%h valid=%b, expected 1255/1", dout[1], dv[1]);
      end
      access(1'b1, 2'b00, 6'd7, 16'h0);
      for (int g = 0; g < 4; g++) begin
         checks++;
         if (dout[g] !== 16'h1255) begin
            errors++;
            $display("FAIL readback7 dut%0d: DO=%h, expected 1255", g, dout[g]);
         end
      end
   endtask

   task automatic test_en_low();
      logic [DW-1:0] prev [4];
      for (int g = 0; g < 4; g++) prev[g] = dout[g];
      access(1'b0, 2'b11, 6'd7, 16'hFFFF);
      for (int g = 0; g < 4; g++) begin
         checks++;
         if (dout[g] !== prev[g] || dv[g] !== 1'b0) begin
            errors++;
            $display("FAIL en_low_hold dut%0d: DO=%h valid=%b, expected %h/0", g, dout[g], dv[g], prev[g]);
         end
      end
      access(1'b1, 2'b00, 6'd7, 16'h0);
      checks++;
      if (dout[0] !== 16'h1255) begin
         errors++;
         $display("FAIL en_low_nowrite: DO=%h, expected 1255", dout[0]);
      end
   endtask

   task automatic test_clr_collision();
      int n;
      int vbad;
      access(1'b1, 2'b11, 6'd3, 16'h1111);
      @(negedge CLK);
      clr = 1'b1; en = 1'b1; we = 2'b11; address = 6'd3; DI = 16'hFFFF;
      @(posedge CLK); #1;
      clr = 1'b0; address = 6'd0; DI = 16'hBEEF;
      n = 0; vbad = 0;
      while (bz[0] === 1'b1 && n < 200) begin
         n++;
         if (dv[0] !== 1'b0) vbad++;
         @(posedge CLK); #1;
      end
      en = 1'b0; we = '0;
      checks++;
      if (n !== 64) begin
         errors++;
         $display("FAIL clr_busy_cycles: got %0d, expected 64", n);
      end
      checks++;
      if (vbad !== 0) begin
         errors++;
         $display("FAIL clr_no_valid: valid high in %0d busy cycles, expected 0", vbad);
      end
      access(1'b1, 2'b00, 6'd3, 16'h0);
      checks++;
      if (dout[0] !== 16'h0000) begin
         errors++;
         $display("FAIL clr_addr3: DO=%h, expected 0000", dout[0]);
      end
      access(1'b1, 2'b00, 6'd0, 16'h0);
      checks++;
      if (dout[0] !== 16'h0000) begin
         errors++;
         $display("FAIL busy_ignores_write addr0: DO=%h, expected 0000", dout[0]);
      end
      access(1'b1, 2'b00, 6'd5, 16'h0);
      checks++;
      if (dout[0] !== 16'h0000) begin
         errors++;
         $display("FAIL clr_addr5: DO=%h, expected 0000", dout[0]);
      end
   endtask

   task automatic test_reset_mid_clear();
      int n;
      int dbad;
      access(1'b1, 2'b11, 6'd10, 16'h5A5A);
      access(1'b1, 2'b00, 6'd10, 16'h0);
      checks++;
      if (dout[0] !== 16'h5A5A) begin
         errors++;
         $display("FAIL pre_reset_read: DO=%h, expected 5a5a", dout[0]);
      end
      @(negedge CLK); clr = 1'b1;
      @(posedge CLK); #1; clr = 1'b0;
      repeat (20) @(posedge CLK);
      @(negedge CLK); RST_N = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (bz[0] !== 1'b1 || dout[0] !== 16'h0000 || dv[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_clear_reset: busy=%b DO=%h valid=%b, expected 1/0000/0", bz[0], dout[0], dv[0]);
      end
      @(negedge CLK); RST_N = 1'b1;
      @(posedge CLK); #1;
      n = 0; dbad = 0;
      while (bz[0] === 1'b1 && n < 200) begin
         n++;
         if (dout[0] !== 16'h0000 || dv[0] !== 1'b0) dbad++;
         @(posedge CLK); #1;
      end
      checks++;
      if (n !== 64) begin
         errors++;
         $display("FAIL restart_busy_cycles: got %0d, expected 64", n);
      end
      checks++;
      if (dbad !== 0) begin
         errors++;
         $display("FAIL restart_outputs_zero: %0d cycles nonzero, expected 0", dbad);
      end
      access(1'b1, 2'b00, 6'd10, 16'h0);
      checks++;
      if (dout[0] !== 16'h0000) begin
         errors++;
         $display("FAIL restart_addr10: DO=%h, expected 0000", dout[0]);
      end
   endtask

   task automatic test_latency();
      logic [DW-1:0] prev;
      access(1'b1, 2'b11, 6'd5, 16'h1234);
      prev = dout[0];
      @(negedge CLK);
      en = 1'b1; we = 2'b00; address = 6'd5;
      @(posedge CLK); #1;
      en = 1'b0;
`ifdef SP_RAM_OUTREG_EN
      checks++;
      if (dout[0] !== prev || dv[0] !== 1'b0) begin
         errors++;
         $display("FAIL lat_edge1: DO=%h valid=%b, expected %h/0", dout[0], dv[0], prev);
      end
      @(posedge CLK); #1;
`endif
      checks++;
      if (dout[0] !== 16'h1234 || dv[0] !== 1'b1) begin
         errors++;
         $display("FAIL lat_load: DO=%h valid=%b, expected 1234/1", dout[0], dv[0]);
      end
      @(posedge CLK); #1;
      checks++;
      if (dout[0] !== 16'h1234 || dv[0] !== 1'b0) begin
         errors++;
         $display("FAIL lat_hold: DO=%h valid=%b, expected 1234/0", dout[0], dv[0]);
      end
   endtask

   initial begin
      test_reset();
      test_power_up_clear();
      test_read_first();
      test_write_first();
      test_en_low();
      test_clr_collision();
      test_reset_mid_clear();
      test_latency();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
      $fatal(1, "timeout");
   end

endmodule
